tile_ram_arbiter: RTL

Arbiter that shares the single-port synchronous tile RAM between the video tile-fetch path and the CPU bus. Each cycle it grants at most one requester, registers that requester's address, write enable and write data onto the RAM port, and returns read data two cycles after the grant. Video has fixed priority. A starvation counter forces a CPU grant after a bounded run of video grants. It sits between the tile fetch sequencer and the tile RAM in the video subsystem.

---
 rtl/tile_ram_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port synchronous tile RAM between video tile fetch (fixed priority)
// and the CPU bus; a starvation counter bounds how long a waiting CPU request can be held off.
module tile_ram_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 8,
   parameter int STARVE = 7,
   parameter int SW     = 3
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

   // Owner of the access in each read-return stage; CPU writes travel as OWN_NONE.
   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_e;

   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          ram_we_q, ram_we_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   owner_e        own1_q, own1_d;
   owner_e        own2_q, own2_d;

   // Handshake: req is a level held with stable fields until gnt; the request is consumed
   // at the clock edge ending the gnt cycle, and req still high afterwards is a new request.
   always_comb begin
      vid_gnt = 1'b0;
      cpu_gnt = 1'b0;
      if (reset_L) begin
         if (cpu_req && (!vid_req || (starve_cnt_q == STARVE_C))) begin
            cpu_gnt = 1'b1;
         end else if (vid_req) begin
            vid_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;
      own1_d       = OWN_NONE;
      own2_d       = own1_q;
      starve_cnt_d = starve_cnt_q;

      if (cpu_gnt) begin
         ram_addr_d  = cpu_addr;
         ram_we_d    = cpu_we;
         ram_wdata_d = cpu_wdata;
         own1_d      = cpu_we ? OWN_NONE : OWN_CPU;
      end else if (vid_gnt) begin
         ram_addr_d  = vid_addr;
         ram_wdata_d = '0;
         own1_d      = OWN_VID;
      end

      // Counts video grants taken while the CPU waits; saturates so the CPU wins next cycle.
      if (!cpu_req || cpu_gnt) begin
         starve_cnt_d = '0;
      end else if (vid_gnt && (starve_cnt_q != STARVE_C)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
         starve_cnt_q <= '0;
         own1_q       <= OWN_NONE;
         own2_q       <= OWN_NONE;
      end else begin
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
         ram_wdata_q  <= ram_wdata_d;
         starve_cnt_q <= starve_cnt_d;
         own1_q       <= own1_d;
         own2_q       <= own2_d;
      end
   end

   assign ram_addr   = ram_addr_q;
   assign ram_we     = ram_we_q;
   assign ram_wdata  = ram_wdata_q;
   assign vid_rvalid = (own2_q == OWN_VID);
   assign cpu_rvalid = (own2_q == OWN_CPU);
   assign vid_rdata  = ram_rdata;
   assign cpu_rdata  = ram_rdata;

endmodule
